// File: rtl/foc_pkg.sv
// Shared constants for the FOC multiplier scheduler: default widths, requester IDs, tag width.
package foc_pkg;

   localparam int FOC_MUL_DW   = 32;
   localparam int FOC_MUL_NREQ = 4;
   localparam int FOC_TAG_W    = $clog2(FOC_MUL_NREQ);

   typedef enum logic [FOC_TAG_W-1:0] {
      REQ_PARK  = FOC_TAG_W'(0),
      REQ_IPARK = FOC_TAG_W'(1),
      REQ_VQLIM = FOC_TAG_W'(2),
      REQ_PI    = FOC_TAG_W'(3)
   } foc_req_e;

endpackage

// File: rtl/foc_rr_arb.sv
// Round-robin arbiter with one-hot grant; prio0_i gives requester 0 fixed top priority
// without moving the round-robin pointer.
module foc_rr_arb
   import foc_pkg::*;
#(
   parameter int NREQ = FOC_MUL_NREQ
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req_i,
   input  logic            prio0_i,
   output logic [NREQ-1:0] gnt_o
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IW-1:0] ptr_q, ptr_d;
   logic          found;
   int            idx;

   always_comb begin
      gnt_o = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      idx   = 0;
      if (prio0_i && req_i[0]) begin
         gnt_o[0] = 1'b1;
         found    = 1'b1;
      end
      // ptr_q names the requester with the highest priority this cycle
      for (int i = 0; i < NREQ; i++) begin
         idx = (int'(ptr_q) + i) % NREQ;
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
            ptr_d      = IW'((idx + 1) % NREQ);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/foc_mul_sched.sv
// Shares one pipelined multiplier among NREQ requesters and routes products back by tag.
// Define FOC_MUL_SCHED_PRIO_EN to give requester 0 fixed top priority over the round-robin.
module foc_mul_sched
   import foc_pkg::*;
#(
   parameter int NREQ    = FOC_MUL_NREQ,
   parameter int DW      = FOC_MUL_DW,
   parameter int MUL_LAT = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_i,
   input  logic [NREQ*DW-1:0] a_i,
   input  logic [NREQ*DW-1:0] b_i,
   input  logic               flush_i,
   output logic [NREQ-1:0]    gnt_o,
   output logic [NREQ-1:0]    rsp_vld_o,
   output logic [2*DW-1:0]    rsp_dat_o,
   output logic [DW-1:0]      mul_a_o,
   output logic [DW-1:0]      mul_b_o,
   input  logic [2*DW-1:0]    mul_data_i,
   output logic               busy_o
);

   localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int NST = MUL_LAT + 1;

`ifdef FOC_MUL_SCHED_PRIO_EN
   localparam logic PRIO0_EN = 1'b1;
`else
   localparam logic PRIO0_EN = 1'b0;
`endif

   logic [NREQ-1:0]          gnt_q, gnt_d, req_eff;
   logic [DW-1:0]            mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic [NST-1:0]           tag_vld_q, tag_vld_d;
   logic [NST-1:0][IW-1:0]   tag_id_q, tag_id_d;
   logic [IW-1:0]            gnt_id;
   logic [NREQ-1:0]          rsp_vld_q, rsp_vld_d;
   logic [2*DW-1:0]          rsp_dat_q, rsp_dat_d;
   logic                     busy_q, busy_d;

   // The requester granted last cycle is still showing its old request, so it sits out one cycle
   assign req_eff = flush_i ? '0 : (req_i & ~gnt_q);

   foc_rr_arb #(.NREQ(NREQ)) u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req_i  (req_eff),
      .prio0_i(PRIO0_EN),
      .gnt_o  (gnt_d)
   );

   always_comb begin
      gnt_id  = '0;
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt_d[k]) begin
            gnt_id  = IW'(k);
            mul_a_d = a_i[k*DW +: DW];
            mul_b_d = b_i[k*DW +: DW];
         end
      end
      tag_vld_d = flush_i ? '0 : {tag_vld_q[NST-2:0], |gnt_d};
      tag_id_d  = {tag_id_q[NST-2:0], gnt_id};
      busy_d    = |tag_vld_d;
   end

   // Last tag stage lines up with the product arriving on mul_data_i
   always_comb begin
      rsp_vld_d = '0;
      rsp_dat_d = rsp_dat_q;
      if (!flush_i && tag_vld_q[NST-1]) begin
         rsp_dat_d = mul_data_i;
         for (int k = 0; k < NREQ; k++) begin
            if (tag_id_q[NST-1] == IW'(k)) rsp_vld_d[k] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q     <= '0;
         mul_a_q   <= '0;
         mul_b_q   <= '0;
         tag_vld_q <= '0;
         tag_id_q  <= '0;
         rsp_vld_q <= '0;
         rsp_dat_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         gnt_q     <= gnt_d;
         mul_a_q   <= mul_a_d;
         mul_b_q   <= mul_b_d;
         tag_vld_q <= tag_vld_d;
         tag_id_q  <= tag_id_d;
         rsp_vld_q <= rsp_vld_d;
         rsp_dat_q <= rsp_dat_d;
         busy_q    <= busy_d;
      end
   end

   assign gnt_o     = gnt_q;
   assign mul_a_o   = mul_a_q;
   assign mul_b_o   = mul_b_q;
   assign rsp_vld_o = rsp_vld_q;
   assign rsp_dat_o = rsp_dat_q;
   assign busy_o    = busy_q;

endmodule

// File: tb/tb_foc_mul_sched.sv
// Randomized bench for foc_mul_sched with a queue-based reference model and directed scenarios.
module tb_foc_mul_sched;

   localparam int NREQ = 4;
   localparam int DW   = 32;
   localparam int LAT  = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req_i = '0;
   logic [NREQ*DW-1:0] a_i = '0;
   logic [NREQ*DW-1:0] b_i = '0;
   logic              flush_i = 1'b0;
   logic [NREQ-1:0]   gnt_o, rsp_vld_o;
   logic [2*DW-1:0]   rsp_dat_o;
   logic [DW-1:0]     mul_a_o, mul_b_o;
   logic [2*DW-1:0]   mul_data_i;
   logic              busy_o;

   int checks = 0;
   int errors = 0;

   foc_mul_sched #(.NREQ(NREQ), .DW(DW), .MUL_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req_i), .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
      .gnt_o(gnt_o), .rsp_vld_o(rsp_vld_o), .rsp_dat_o(rsp_dat_o), .mul_a_o(mul_a_o),
      .mul_b_o(mul_b_o), .mul_data_i(mul_data_i), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   // Two-stage signed multiplier standing in for the shared datapath instance
   logic signed [63:0] mp1 = '0, mp2 = '0, msa, msb;
   always_comb begin
      msa = $signed(mul_a_o);
      msb = $signed(mul_b_o);
   end
   always @(posedge clk) begin
      mp1 <= msa * msb;
      mp2 <= mp1;
   end
   assign mul_data_i = mp2;

   // Reference model: each granted op carries its product and the edges left until it is reported
   typedef struct {
      int          id;
      logic [63:0] p;
      int          rem;
   } op_t;
   op_t q[$];

   int              m_ptr = 0;
   int              m_w, m_idx;
   logic [NREQ-1:0] m_cand;
   logic [NREQ-1:0] exp_gnt = '0, exp_rsp_vld = '0;
   logic [63:0]     exp_rsp_dat = '0;
   logic [31:0]     exp_a = '0, exp_b = '0;
   logic            exp_busy = 1'b0;
   logic signed [63:0] m_sa, m_sb;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_ptr = 0; exp_gnt = '0; exp_rsp_vld = '0; exp_rsp_dat = '0;
         exp_a = '0; exp_b = '0; exp_busy = 1'b0;
      end else begin
         exp_rsp_vld = '0;
         foreach (q[i]) q[i].rem = q[i].rem - 1;
         if (q.size() > 0 && q[0].rem == 0) begin
            if (!flush_i) begin
               exp_rsp_vld[q[0].id] = 1'b1;
               exp_rsp_dat = q[0].p;
            end
            void'(q.pop_front());
         end
         if (flush_i) q.delete();
         m_cand = flush_i ? '0 : (req_i & ~exp_gnt);
         m_w = -1;
`ifdef FOC_MUL_SCHED_PRIO_EN
         if (m_cand[0]) m_w = 0;
`endif
         if (m_w < 0) begin
            for (int i = 0; i < NREQ; i++) begin
               m_idx = (m_ptr + i) % NREQ;
               if (m_w < 0 && m_cand[m_idx]) m_w = m_idx;
            end
            if (m_w >= 0) m_ptr = (m_w + 1) % NREQ;
         end
         exp_gnt = '0;
         if (m_w >= 0) begin
            exp_gnt[m_w] = 1'b1;
            exp_a = a_i[m_w*DW +: DW];
            exp_b = b_i[m_w*DW +: DW];
            m_sa = $signed(exp_a);
            m_sb = $signed(exp_b);
            q.push_back('{id: m_w, p: m_sa * m_sb, rem: LAT + 1});
         end
         exp_busy = (q.size() > 0);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("gnt", 64'(gnt_o), 64'(exp_gnt));
      chk("rsp_vld", 64'(rsp_vld_o), 64'(exp_rsp_vld));
      chk("rsp_dat", rsp_dat_o, exp_rsp_dat);
      chk("mul_a", 64'(mul_a_o), 64'(exp_a));
      chk("mul_b", 64'(mul_b_o), 64'(exp_b));
      chk("busy", 64'(busy_o), 64'(exp_busy));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int k, input logic [31:0] a, input logic [31:0] b);
      a_i[k*DW +: DW] = a;
      b_i[k*DW +: DW] = b;
   endtask

   task automatic wait_rsp(input int k, input string name, input logic [63:0] exp);
      bit seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         step();
         if (rsp_vld_o[k]) begin
            seen = 1'b1;
            chk(name, rsp_dat_o, exp);
         end
      end
      if (!seen) chk({name, "_timeout"}, 64'd0, 64'd1);
   endtask

   logic [NREQ-1:0] prev_g;
   bit              seen0;

   initial begin
      #12;
      chk("reset_gnt", 64'(gnt_o), 64'd0);
      chk("reset_busy", 64'(busy_o), 64'd0);
      chk("reset_mul_a", 64'(mul_a_o), 64'd0);
      rst_n = 1'b1;
      step();

      // Single op: 3*5
      set_op(0, 32'd3, 32'd5);
      req_i = 4'b0001;
      step();
      chk("t1_gnt", 64'(gnt_o), 64'h1);
      chk("t1_mul_a", 64'(mul_a_o), 64'd3);
      chk("t1_mul_b", 64'(mul_b_o), 64'd5);
      req_i = '0;
      step();
      chk("t1_busy1", 64'(busy_o), 64'd1);
      step();
      chk("t1_busy2", 64'(busy_o), 64'd1);
      chk("t1_norsp", 64'(rsp_vld_o), 64'd0);
      step();
      chk("t1_rsp_vld", 64'(rsp_vld_o), 64'h1);
      chk("t1_rsp_dat", rsp_dat_o, 64'd15);

      // Contention: every grant must advance by one, never repeat
      for (int k = 0; k < NREQ; k++) set_op(k, 32'(k + 1), 32'(100 * (k + 1)));
      req_i = 4'hF;
      step();
      prev_g = gnt_o;
      for (int n = 0; n < 10; n++) begin
         step();
         chk("t2_rotate", 64'(gnt_o), 64'({prev_g[NREQ-2:0], prev_g[NREQ-1]}));
         prev_g = gnt_o;
      end
      req_i = '0;
      repeat (6) step();

      // Signed pass-through
      set_op(1, 32'hFFFF_FFFE, 32'd7);
      req_i = 4'b0010;
      step();
      req_i = '0;
      wait_rsp(1, "t3_signed", 64'hFFFF_FFFF_FFFF_FFF2);
      repeat (2) step();

      // Flush with two ops in flight and requester 2 waiting
      set_op(0, 32'd11, 32'd13);
      set_op(1, 32'd17, 32'd19);
      req_i = 4'b0011;
      step();
      step();
      req_i = '0;
      set_op(2, 32'd6, 32'd9);
      req_i[2] = 1'b1;
      flush_i = 1'b1;
      step();
      chk("t4_gnt_during_flush", 64'(gnt_o), 64'd0);
      chk("t4_busy", 64'(busy_o), 64'd0);
      flush_i = 1'b0;
      step();
      chk("t4_gnt_after", 64'(gnt_o), 64'h4);
      req_i = '0;
      wait_rsp(2, "t4_rsp2", 64'd54);
      repeat (2) step();

      // Async reset mid-stream
      for (int k = 0; k < NREQ; k++) set_op(k, $urandom, $urandom);
      req_i = 4'hF;
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_gnt", 64'(gnt_o), 64'd0);
      chk("t5_busy", 64'(busy_o), 64'd0);
      chk("t5_rsp_dat", rsp_dat_o, 64'd0);
      chk("t5_mul_b", 64'(mul_b_o), 64'd0);
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("t5_first_gnt", 64'(gnt_o), 64'h1);
      req_i = '0;
      repeat (6) step();

      // Requester 0 joins while 1..3 contend
      req_i = 4'b1110;
      step();
      step();
      req_i[0] = 1'b1;
      step();
`ifdef FOC_MUL_SCHED_PRIO_EN
      chk("t6_prio_gnt0", 64'(gnt_o), 64'h1);
`else
      seen0 = gnt_o[0];
      for (int n = 0; n < 3 && !seen0; n++) begin
         step();
         seen0 = gnt_o[0];
      end
      chk("t6_rr_gnt0", 64'(seen0), 64'd1);
`endif
      req_i = '0;
      repeat (6) step();

      // Random traffic honouring the hold-until-grant handshake
      for (int n = 0; n < 2000; n++) begin
         step();
         for (int k = 0; k < NREQ; k++) begin
            if (req_i[k] && gnt_o[k]) begin
               if ($urandom_range(0, 1) == 0) req_i[k] = 1'b0;
               else set_op(k, $urandom, $urandom);
            end else if (!req_i[k] && $urandom_range(0, 2) == 0) begin
               req_i[k] = 1'b1;
               set_op(k, $urandom, $urandom);
            end
         end
         flush_i = ($urandom_range(0, 19) == 0);
      end
      flush_i = 1'b0;
      step();
      req_i = '0;
      repeat (8) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
